// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the RAM port arbiter slice.
package ram_arb_pkg;

    localparam int unsigned ARB_AW         = 8;
    localparam int unsigned ARB_DW         = 8;
    localparam int unsigned ARB_STARVE_MAX = 4;
    localparam int unsigned STARVE_CW      = 4;

    typedef enum logic [1:0] {
        IDLE,
        CPU_OWN,
        HOST_OWN,
        HOST_LOCK
    } arb_state_e;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_CPU,
        RD_HOST
    } rd_owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating host-starvation counter: counts cycles the host waits, flags MAX.
module arb_starve_cnt
    import ram_arb_pkg::*;
#(
    parameter int unsigned MAX = ARB_STARVE_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [STARVE_CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != STARVE_CW'(MAX))) begin
            cnt_d = cnt_q + STARVE_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == STARVE_CW'(MAX));

endmodule

// File: rtl/ram_port_arbiter.sv
// CPU/host arbiter for a single-port RAM: one access per cycle, read data steered to owner.
// Optional macro ARB_ROUND_ROBIN_EN replaces CPU priority + starvation bound with round-robin.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW         = ARB_AW,
    parameter int unsigned DW         = ARB_DW,
    parameter int unsigned STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_rden,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q
);

    arb_state_e state_q, state_d;
    rd_owner_e  rd_owner_q, rd_owner_d;

`ifndef ARB_ROUND_ROBIN_EN
    logic starve_max;

    arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst_n  (rst),
        .inc    (host_req & ~host_gnt),
        .clr    (host_gnt | ~host_req),
        .at_max (starve_max)
    );
`endif

    // Grants are qualified by rst so nothing reaches the RAM while reset is asserted.
    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (rst) begin
            if (state_q == HOST_LOCK) begin
                host_gnt = host_req;
            end else begin
`ifdef ARB_ROUND_ROBIN_EN
                if (cpu_req && host_req) begin
                    if (state_q == CPU_OWN) begin
                        host_gnt = 1'b1;
                    end else begin
                        cpu_gnt = 1'b1;
                    end
                end else begin
                    cpu_gnt  = cpu_req;
                    host_gnt = host_req;
                end
`else
                host_gnt = host_req & (~cpu_req | starve_max);
                cpu_gnt  = cpu_req & ~host_gnt;
`endif
            end
        end
    end

    // Leaving the lock always goes through IDLE so the CPU wins the following cycle.
    always_comb begin
        state_d = IDLE;
        if (state_q == HOST_LOCK && !host_lock) begin
            state_d = IDLE;
        end else if (host_gnt && host_lock) begin
            state_d = HOST_LOCK;
        end else if (host_gnt) begin
            state_d = HOST_OWN;
        end else if (cpu_gnt) begin
            state_d = CPU_OWN;
        end else if (state_q == HOST_LOCK) begin
            state_d = HOST_LOCK;
        end
    end

    always_comb begin
        rd_owner_d = RD_NONE;
        if (cpu_gnt && !cpu_we) begin
            rd_owner_d = RD_CPU;
        end else if (host_gnt && !host_we) begin
            rd_owner_d = RD_HOST;
        end
    end

    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        ram_rden = 1'b0;
        ram_wren = 1'b0;
        if (cpu_gnt) begin
            ram_addr = cpu_addr;
            ram_data = cpu_wdata;
            ram_rden = ~cpu_we;
            ram_wren = cpu_we;
        end else if (host_gnt) begin
            ram_addr = host_addr;
            ram_data = host_wdata;
            ram_rden = ~host_we;
            ram_wren = host_we;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rd_owner_q <= RD_NONE;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign cpu_stall   = cpu_req & ~cpu_gnt;
    assign cpu_rvalid  = (rd_owner_q == RD_CPU);
    assign host_rvalid = (rd_owner_q == RD_HOST);
    assign rdata       = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: RAM model, shadow memory and read-return scoreboard.
module tb_ram_port_arbiter;

    localparam int SMAX = 4;

    logic       clk;
    logic       rst;
    logic       cpu_req, cpu_we, host_req, host_we, host_lock;
    logic [7:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
    logic       cpu_gnt, cpu_stall, cpu_rvalid, host_gnt, host_rvalid;
    logic [7:0] rdata, ram_addr, ram_data, ram_q;
    logic       ram_rden, ram_wren;

    logic [7:0] mem    [256];
    logic [7:0] sh_mem [256];

    typedef struct {
        logic       host;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_mis = 0;

    ram_port_arbiter #(
        .AW         (8),
        .DW         (8),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_stall   (cpu_stall),
        .cpu_rvalid  (cpu_rvalid),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_lock   (host_lock),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .rdata       (rdata),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .ram_rden    (ram_rden),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-output single-port RAM.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        if (ram_rden) ram_q <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        host_lock = 1'b0;
    endtask

    // Sample at the falling edge, check the grant pair and RAM drive, and book the expected read.
    task automatic exp_grant(input string tag, input logic cg, input logic hg);
        @(negedge clk);
        check({tag, "_cpu_gnt"}, 32'(cpu_gnt), 32'(cg));
        check({tag, "_host_gnt"}, 32'(host_gnt), 32'(hg));
        check({tag, "_stall"}, 32'(cpu_stall), 32'(cpu_req & ~cg));
        if (cg) begin
            check({tag, "_addr"}, 32'(ram_addr), 32'(cpu_addr));
            check({tag, "_strb"}, 32'({ram_rden, ram_wren}), 32'({~cpu_we, cpu_we}));
            if (cpu_we) begin
                check({tag, "_wdata"}, 32'(ram_data), 32'(cpu_wdata));
                sh_mem[cpu_addr] = cpu_wdata;
            end else begin
                sb.push_back('{host: 1'b0, data: sh_mem[cpu_addr]});
            end
        end else if (hg) begin
            check({tag, "_addr"}, 32'(ram_addr), 32'(host_addr));
            check({tag, "_strb"}, 32'({ram_rden, ram_wren}), 32'({~host_we, host_we}));
            if (host_we) begin
                check({tag, "_wdata"}, 32'(ram_data), 32'(host_wdata));
                sh_mem[host_addr] = host_wdata;
            end else begin
                sb.push_back('{host: 1'b1, data: sh_mem[host_addr]});
            end
        end else begin
            check({tag, "_idle_drv"}, 32'({ram_addr, ram_rden, ram_wren}), 32'(0));
        end
    endtask

    // Read-return monitor: every rvalid must match the oldest booked read.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_rvalid && host_rvalid) check("rvalid_both", 32'(1), 32'(0));
            if (cpu_rvalid || host_rvalid) begin
                if (sb.size() == 0) begin
                    check("rvalid_unexpected", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("rv_owner", 32'(host_rvalid), 32'(e.host));
                    check("rdata", 32'(rdata), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic last_cpu;
        int   cnt;
        logic cg, hg;

        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'(i * 7 + 3);
            sh_mem[i] = 8'(i * 7 + 3);
        end
        mem[5] = 8'h3C; sh_mem[5] = 8'h3C;
        ram_q  = '0;

        // Reset with a pending CPU request: nothing may be granted or driven.
        clr_in();
        rst = 1'b0;
        cpu_req = 1'b1; cpu_addr = 8'h05;
        @(negedge clk);
        check("rst_gnt", 32'({cpu_gnt, host_gnt}), 32'(0));
        check("rst_strb", 32'({ram_rden, ram_wren}), 32'(0));
        check("rst_bus", 32'({ram_addr, ram_data}), 32'(0));
        check("rst_rvalid", 32'({cpu_rvalid, host_rvalid}), 32'(0));
        adv();
        adv();
        rst = 1'b1;

        // CPU-only read of RAM[5].
        exp_grant("cpu_rd5", 1'b1, 1'b0);
        adv();
        clr_in();

        // Host write while idle, then CPU reads it back.
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'hA5;
        exp_grant("host_wr", 1'b0, 1'b1);
        adv();
        clr_in();
        cpu_req = 1'b1; cpu_addr = 8'h10;
        exp_grant("cpu_rd10", 1'b1, 1'b0);
        adv();
        clr_in();

        // Back-to-back host reads.
        host_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_addr = 8'(8'h20 + i);
            exp_grant("host_b2b", 1'b0, 1'b1);
            adv();
        end
        clr_in();

        // Read then write of the same address returns old data; later read sees new.
        cpu_req = 1'b1; cpu_addr = 8'h30;
        exp_grant("rbw_rd", 1'b1, 1'b0);
        adv();
        cpu_we = 1'b1; cpu_wdata = 8'h77;
        exp_grant("rbw_wr", 1'b1, 1'b0);
        adv();
        cpu_we = 1'b0;
        exp_grant("rbw_rd2", 1'b1, 1'b0);
        adv();
        clr_in();
        exp_grant("gap0", 1'b0, 1'b0);
        adv();

        // Both requesting continuously.
        cpu_req = 1'b1; cpu_addr = 8'h40;
        host_req = 1'b1; host_addr = 8'h50;
        last_cpu = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            hg = last_cpu;
`else
            hg = (cnt == SMAX);
            cnt = hg ? 0 : ((cnt < SMAX) ? cnt + 1 : cnt);
`endif
            cg = ~hg;
            last_cpu = cg;
            exp_grant("contend", cg, hg);
            adv();
        end
        clr_in();
        exp_grant("gap1", 1'b0, 1'b0);
        adv();

        // Host lock holds off the CPU until one cycle after lock drops.
        host_req = 1'b1; host_lock = 1'b1; host_addr = 8'h60;
        exp_grant("lock0", 1'b0, 1'b1);
        adv();
        cpu_req = 1'b1; cpu_addr = 8'h41;
        for (int i = 0; i < 3; i++) begin
            host_addr = 8'(8'h61 + i);
            exp_grant("lock_hold", 1'b0, 1'b1);
            adv();
        end
        host_req = 1'b0; host_lock = 1'b0;
        exp_grant("lock_drop", 1'b0, 1'b0);
        adv();
        exp_grant("lock_after", 1'b1, 1'b0);
        adv();
        clr_in();
        exp_grant("gap2", 1'b0, 1'b0);
        adv();

        // Reset while a read is in flight: the read is dropped.
        cpu_req = 1'b1; cpu_addr = 8'h05;
        @(negedge clk);
        check("midrd_gnt", 32'(cpu_gnt), 32'(1));
        rst = 1'b0;
        @(negedge clk);
        check("midrd_gnt_rst", 32'({cpu_gnt, host_gnt, cpu_stall}), 32'(3'b001));
        check("midrd_strb", 32'({ram_rden, ram_wren}), 32'(0));
        check("midrd_bus", 32'({ram_addr, ram_data}), 32'(0));
        check("midrd_rvalid", 32'({cpu_rvalid, host_rvalid}), 32'(0));
        adv();
        rst = 1'b1;
        exp_grant("post_rst", 1'b1, 1'b0);
        adv();
        clr_in();

        for (int i = 0; i < 3; i++) adv();
        check("sb_drained", 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
